// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs 3 bytes per 20-bit
// word and writes consecutive addresses, holding busy while a load runs.
module imem_loader #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_count,
   input  logic              byte_vld,
   input  logic [7:0]        byte_data,
   output logic              byte_rdy,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_waddr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Handshake: a byte moves only on a posedge where byte_vld && byte_rdy;
   // byte_rdy is high exactly while the FSM sits in B0, B1 or B2.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_B0   = 3'd1,
      S_B1   = 3'd2,
      S_B2   = 3'd3,
      S_WR   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [ADDR_W:0] LAST_WORD = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [15:0]       asm_lo;
   logic              accept;

   assign accept = byte_vld && byte_rdy;

   // Outputs are registers updated alongside state so each tracks its state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         addr      <= '0;
         remaining <= '0;
         asm_lo    <= '0;
         byte_rdy  <= 1'b0;
         im_we     <= 1'b0;
         im_waddr  <= '0;
         im_wdata  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         im_we <= 1'b0;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_start) begin
                  addr      <= load_base;
                  remaining <= load_count;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  if (load_count == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= S_B0;
                     byte_rdy <= 1'b1;
                  end
               end
            end
            S_B0: begin
               if (accept) begin
                  asm_lo[7:0] <= byte_data;
                  state       <= S_B1;
               end
            end
            S_B1: begin
               if (accept) begin
                  asm_lo[15:8] <= byte_data;
                  state        <= S_B2;
               end
            end
            S_B2: begin
               // Write port fields change only here, so they hold between writes.
               if (accept) begin
                  im_wdata <= {byte_data[3:0], asm_lo};
                  im_waddr <= addr;
                  im_we    <= 1'b1;
                  byte_rdy <= 1'b0;
                  if (byte_data[7:4] != 4'd0) err <= 1'b1;
                  state    <= S_WR;
               end
            end
            S_WR: begin
               addr      <= addr + 1'b1;
               remaining <= remaining - 1'b1;
               if (remaining == LAST_WORD) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state    <= S_B0;
                  byte_rdy <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               byte_rdy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table, directed corner sequences and random
// loads checked against a per-word packing model.
module tb_imem_loader;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 20;
   localparam int W      = ADDR_W + DATA_W;

   logic              clk;
   logic              rst;
   logic              load_start;
   logic [ADDR_W-1:0] load_base;
   logic [ADDR_W:0]   load_count;
   logic              byte_vld;
   logic [7:0]        byte_data;
   logic              byte_rdy;
   logic              im_we;
   logic [ADDR_W-1:0] im_waddr;
   logic [DATA_W-1:0] im_wdata;
   logic              busy;
   logic              done;
   logic              err;

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_start(load_start),
      .load_base (load_base),
      .load_count(load_count),
      .byte_vld  (byte_vld),
      .byte_data (byte_data),
      .byte_rdy  (byte_rdy),
      .im_we     (im_we),
      .im_waddr  (im_waddr),
      .im_wdata  (im_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] cap_q[$];
   logic [7:0]   stream[$];
   int done_cnt;
   bit rdy_seen;

   always @(negedge clk) begin
      if (!rst) begin
         if (im_we) cap_q.push_back({im_waddr, im_wdata});
         if (done) done_cnt++;
         if (byte_rdy) rdy_seen = 1'b1;
      end
   end

   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [19:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
      int n;
      n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      if (busy) check("idle_before_start", 64'(busy), 64'd0);
      load_base  = b;
      load_count = c;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int n;
      bit ok;
      repeat ($urandom_range(max_gap, 0)) tick();
      byte_vld  = 1'b1;
      byte_data = b;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 60) begin
         ok = byte_rdy;
         tick();
         n++;
      end
      if (!ok) check("byte_accept", 64'(ok), 64'd1);
      byte_vld  = 1'b0;
      byte_data = 8'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check("done_pulse", 64'(done), 64'd1);
      tick();
      check("busy_after_done", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);
   endtask

   task automatic compare_writes(input string name);
      logic [W-1:0] e;
      logic [W-1:0] a;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (cap_q.size() > 0) a = cap_q.pop_front();
         else a = 'x;
         check(name, 64'(a), 64'(e));
      end
      check({name, "_extra_writes"}, 64'(cap_q.size()), 64'd0);
      cap_q.delete();
   endtask

   // Reference: word i lands at (base+i) mod 2^ADDR_W as {b2[3:0], b1, b0}.
   task automatic model_load(input int base, input int count, output bit exp_err);
      int a;
      exp_err = 1'b0;
      for (int i = 0; i < count; i++) begin
         logic [7:0] lo, mid, hi;
         lo  = stream[3*i];
         mid = stream[3*i+1];
         hi  = stream[3*i+2];
         a   = (base + i) % (1 << ADDR_W);
         exp_q.push_back({13'(a), hi[3:0], mid, lo});
         if (hi[7:4] != 4'd0) exp_err = 1'b1;
      end
   endtask

   task automatic run_load(input string name, input int base, input int count, input int gap);
      bit exp_err;
      model_load(base, count, exp_err);
      done_cnt = 0;
      cap_q.delete();
      start_load(13'(base), 14'(count));
      foreach (stream[i]) send_byte(stream[i], gap);
      wait_done();
      compare_writes(name);
      check({name, "_err"}, 64'(err), 64'(exp_err));
      check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
   endtask

   task automatic mid_cycle_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_byte_rdy", 64'(byte_rdy), 64'd0);
      check("rst_im_we", 64'(im_we), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_waddr", 64'(im_waddr), 64'd0);
      check("rst_wdata", 64'(im_wdata), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bit e;
      int base, cnt;
      rst = 1'b1;
      load_start = 1'b0;
      load_base = '0;
      load_count = '0;
      byte_vld = 1'b0;
      byte_data = '0;
      done_cnt = 0;
      rdy_seen = 1'b0;
      #1;
      check("por_busy", 64'(busy), 64'd0);
      check("por_waddr", 64'(im_waddr), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tick();

      // T2 basic load
      stream = '{8'h34, 8'h12, 8'h0A, 8'h78, 8'h56, 8'h0B};
      exp_q.push_back({13'h0010, 20'hA1234});
      exp_q.push_back({13'h0011, 20'hB5678});
      done_cnt = 0;
      start_load(13'h0010, 14'd2);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      send_byte(8'h0A, 0);
      check("t2_we_after_third_byte", 64'(im_we), 64'd1);
      check("t2_rdy_low_in_wr", 64'(byte_rdy), 64'd0);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h0B, 0);
      wait_done();
      compare_writes("t2_write");
      check("t2_done_cnt", 64'(done_cnt), 64'd1);
      check("t2_waddr_hold", 64'(im_waddr), 64'h11);
      check("t2_wdata_hold", 64'(im_wdata), 64'hB5678);

      // T1 asynchronous reset with non-zero outputs
      mid_cycle_reset();

      // vector table: single-word loads
      vecs[0] = '{8'h34, 8'h12, 8'h0A, 20'hA1234, 1'b0};
      vecs[1] = '{8'hFF, 8'hFF, 8'h0F, 20'hFFFFF, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 8'h10, 20'h00000, 1'b1};
      vecs[3] = '{8'hAB, 8'hCD, 8'hEF, 20'hFCDAB, 1'b1};
      vecs[4] = '{8'h01, 8'h80, 8'h05, 20'h58001, 1'b0};
      vecs[5] = '{8'h5A, 8'hA5, 8'hF3, 20'h3A55A, 1'b1};
      for (int i = 0; i < 6; i++) begin
         cap_q.delete();
         exp_q.push_back({13'(13'h100 + i), vecs[i].exp_data});
         start_load(13'(13'h100 + i), 14'd1);
         send_byte(vecs[i].b0, 1);
         send_byte(vecs[i].b1, 1);
         send_byte(vecs[i].b2, 1);
         wait_done();
         compare_writes("vec_write");
         check("vec_err", 64'(err), 64'(vecs[i].exp_err));
      end

      // T3 wrap at top of address space
      stream = '{8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h06};
      exp_q.push_back({13'h1FFF, 20'h32211});
      exp_q.push_back({13'h0000, 20'h65544});
      done_cnt = 0;
      cap_q.delete();
      start_load(13'h1FFF, 14'd2);
      foreach (stream[i]) send_byte(stream[i], 2);
      wait_done();
      compare_writes("t3_wrap");

      // T4 zero count
      cap_q.delete();
      done_cnt = 0;
      rdy_seen = 1'b0;
      start_load(13'h0055, 14'd0);
      check("t4_done_next_cycle", 64'(done), 64'd1);
      check("t4_busy_in_done", 64'(busy), 64'd1);
      tick();
      check("t4_done_low", 64'(done), 64'd0);
      check("t4_busy_low", 64'(busy), 64'd0);
      tick();
      check("t4_no_write", 64'(cap_q.size()), 64'd0);
      check("t4_rdy_never", 64'(rdy_seen), 64'd0);
      check("t4_done_cnt", 64'(done_cnt), 64'd1);

      // T5 format error, then restart clears it
      stream = '{8'h00, 8'h00, 8'h1F};
      run_load("t5_fmt", 32'h20, 1, 0);
      check("t5_wdata", 64'(im_wdata), 64'hF0000);
      start_load(13'h0030, 14'd1);
      check("t5_err_cleared", 64'(err), 64'd0);
      send_byte(8'h21, 0);
      send_byte(8'h43, 0);
      send_byte(8'h05, 0);
      exp_q.push_back({13'h0030, 20'h54321});
      wait_done();
      compare_writes("t5_restart");
      check("t5_err_after", 64'(err), 64'd0);

      // T6a: start pulse while busy is ignored; err from word 0 survives it
      stream.delete();
      for (int i = 0; i < 9; i++) stream.push_back(8'($urandom));
      stream[2] = 8'h90 | (stream[2] & 8'h0F);
      model_load(32'h40, 3, e);
      done_cnt = 0;
      cap_q.delete();
      start_load(13'h0040, 14'd3);
      for (int i = 0; i < 5; i++) send_byte(stream[i], 3);
      load_base  = 13'h1234;
      load_count = 14'd7;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("t6_err_kept", 64'(err), 64'd1);
      for (int i = 5; i < 9; i++) send_byte(stream[i], 3);
      wait_done();
      compare_writes("t6_ignored_start");
      check("t6_done_cnt", 64'(done_cnt), 64'd1);

      // T6b: reset after two bytes of the second word
      stream = '{8'hA1, 8'hB2, 8'h0C, 8'hD4, 8'hE5};
      exp_q.push_back({13'h0060, 20'hCB2A1});
      cap_q.delete();
      start_load(13'h0060, 14'd2);
      foreach (stream[i]) send_byte(stream[i], 1);
      mid_cycle_reset();
      repeat (4) tick();
      compare_writes("t6_rst_partial");
      stream = '{8'h07, 8'h08, 8'h09};
      run_load("t6_after_rst", 32'h70, 1, 0);

      // random loads against the model
      for (int t = 0; t < 10; t++) begin
         base = (t % 3 == 0) ? $urandom_range(8191, 8188) : $urandom_range(8191, 0);
         cnt  = $urandom_range(6, 1);
         stream.delete();
         for (int i = 0; i < 3 * cnt; i++) stream.push_back(8'($urandom));
         run_load("rand_load", base, cnt, 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
